// File: rtl/n_bin_readout.sv
// Bin-averaging readout: counts FFT frames, snapshots the averaged bin vector once
// per completed average and streams the bins out one per valid/ready beat.
module n_bin_readout #(
    parameter int unsigned N             = 16,
    parameter int unsigned N_AVGS        = 7,
    parameter int unsigned BINS          = 4,
    parameter int unsigned CAPTURE_DELAY = 2
) (
    input  logic                        clk,
    input  logic                        arest_n,
    input  logic                        fft_valid,
    input  logic [BINS-1:0][N-1:0]      avg_data,
    output logic [N-1:0]                m_data,
    output logic [$clog2(BINS)-1:0]     m_bin,
    output logic                        m_valid,
    output logic                        m_last,
    input  logic                        m_ready,
    output logic                        overrun,
    input  logic                        clear_overrun,
    output logic [N_AVGS-1:0]           frame_cnt
);

    localparam int unsigned BW = $clog2(BINS);
    localparam logic [BW-1:0]     LAST_BIN   = BW'(BINS - 1);
    localparam logic [N_AVGS-1:0] LAST_FRAME = '1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                   state;
    logic [CAPTURE_DELAY-1:0] pipe;
    logic [BINS-1:0][N-1:0]   snap;

    logic          terminal_c;
    logic          capture_c;
    logic          hs_c;
    logic          final_hs_c;
    logic [BW-1:0] next_bin_c;

    assign terminal_c = fft_valid && (frame_cnt == LAST_FRAME);
    assign capture_c  = pipe[CAPTURE_DELAY-1];
    assign hs_c       = m_valid & m_ready;
    // m_last is only ever high in STREAM on the final bin
    assign final_hs_c = hs_c & m_last;
    assign next_bin_c = m_bin + BW'(1);

    // Frame counter, wraps naturally at 2^N_AVGS
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            frame_cnt <= '0;
        end else if (fft_valid) begin
            frame_cnt <= frame_cnt + N_AVGS'(1);
        end
    end

    // Capture delay pipe; the concatenation drops the oldest bit
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            pipe <= '0;
        end else begin
            pipe <= CAPTURE_DELAY'({pipe, terminal_c});
        end
    end

    // Snapshot / streaming FSM with registered beat outputs
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            state   <= IDLE;
            snap    <= '0;
            m_data  <= '0;
            m_bin   <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture_c) begin
                        state   <= STREAM;
                        snap    <= avg_data;
                        m_data  <= avg_data[0];
                        m_bin   <= '0;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (final_hs_c) begin
                        if (capture_c) begin
                            snap    <= avg_data;
                            m_data  <= avg_data[0];
                            m_bin   <= '0;
                            m_last  <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                        end
                    end else if (hs_c) begin
                        m_bin  <= next_bin_c;
                        m_data <= snap[next_bin_c];
                        m_last <= (next_bin_c == LAST_BIN);
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge arest_n) begin
        if (!arest_n) begin
            overrun <= 1'b0;
        end else if (capture_c && (state == STREAM) && !final_hs_c) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_n_bin_readout.sv
// Directed bench for n_bin_readout with BINS=4, N=16, N_AVGS=2, CAPTURE_DELAY=2.
module tb_n_bin_readout;

    logic                 clk;
    logic                 arest_n;
    logic                 fft_valid;
    logic [3:0][15:0]     avg_data;
    logic [15:0]          m_data;
    logic [1:0]           m_bin;
    logic                 m_valid;
    logic                 m_last;
    logic                 m_ready;
    logic                 overrun;
    logic                 clear_overrun;
    logic [1:0]           frame_cnt;

    int vectors = 0;
    int errs    = 0;

    logic [3:0][15:0] data_a;
    logic [3:0][15:0] data_b;
    logic [3:0][15:0] data_c;

    n_bin_readout #(
        .N(16), .N_AVGS(2), .BINS(4), .CAPTURE_DELAY(2)
    ) dut (
        .clk(clk), .arest_n(arest_n), .fft_valid(fft_valid), .avg_data(avg_data),
        .m_data(m_data), .m_bin(m_bin), .m_valid(m_valid), .m_last(m_last),
        .m_ready(m_ready), .overrun(overrun), .clear_overrun(clear_overrun),
        .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},    32'(m_data),    32'h0);
        chk({tag, "_bin"},     32'(m_bin),     32'h0);
        chk({tag, "_valid"},   32'(m_valid),   32'h0);
        chk({tag, "_last"},    32'(m_last),    32'h0);
        chk({tag, "_overrun"}, 32'(overrun),   32'h0);
        chk({tag, "_fcnt"},    32'(frame_cnt), 32'h0);
    endtask

    // Four fft_valid pulses 10 cycles apart; returns in the cycle after the terminal pulse
    task automatic average();
        for (int p = 0; p < 4; p++) begin
            fft_valid = 1'b1;
            tick();
            fft_valid = 1'b0;
            if (p < 3) repeat (9) tick();
        end
    endtask

    // Expects m_valid already high; checks 4 beats, optionally with ready pattern 1,0,0
    task automatic stream(input string tag, input logic [3:0][15:0] exp, input bit bp);
        int beat = 0;
        int cyc  = 0;
        while (beat < 4 && cyc < 40) begin
            m_ready = bp ? (cyc % 3 == 0) : 1'b1;
            chk({tag, "_valid"}, 32'(m_valid), 32'h1);
            chk({tag, "_data"},  32'(m_data),  32'(exp[beat]));
            chk({tag, "_bin"},   32'(m_bin),   32'(beat));
            chk({tag, "_last"},  32'(m_last),  32'(beat == 3));
            if (m_ready && m_valid) beat++;
            tick();
            cyc++;
        end
        chk({tag, "_done"}, 32'(beat), 32'd4);
    endtask

    initial begin
        int streams;
        int seen_valid;

        data_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        data_b = {16'h00d0, 16'h00c0, 16'h00b0, 16'h00a0};
        data_c = {16'hbeef, 16'hcafe, 16'h1234, 16'h5678};

        arest_n       = 1'b0;
        fft_valid     = 1'b0;
        avg_data      = data_a;
        m_ready       = 1'b1;
        clear_overrun = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        arest_n = 1'b1;
        tick();

        // Basic
        for (int p = 0; p < 4; p++) begin
            fft_valid = 1'b1;
            tick();
            fft_valid = 1'b0;
            chk("basic_fcnt", 32'(frame_cnt), 32'((p + 1) % 4));
            if (p < 3) repeat (9) tick();
        end
        chk("basic_lat1", 32'(m_valid), 32'h0);
        tick();
        chk("basic_lat2", 32'(m_valid), 32'h0);
        tick();
        stream("basic", data_a, 1'b0);
        chk("basic_after_valid", 32'(m_valid), 32'h0);
        chk("basic_overrun", 32'(overrun), 32'h0);
        repeat (5) tick();

        // Backpressure
        average();
        tick();
        tick();
        stream("bp", data_a, 1'b1);
        chk("bp_after_valid", 32'(m_valid), 32'h0);
        chk("bp_overrun", 32'(overrun), 32'h0);
        m_ready = 1'b1;
        repeat (5) tick();

        // Overrun: second average lands while first snapshot is stalled
        m_ready  = 1'b0;
        avg_data = data_a;
        average();
        tick();
        tick();
        chk("ovr_valid", 32'(m_valid), 32'h1);
        avg_data = data_b;
        average();
        tick();
        tick();
        chk("ovr_set", 32'(overrun), 32'h1);
        stream("ovr", data_a, 1'b0);
        chk("ovr_after_valid", 32'(m_valid), 32'h0);
        repeat (10) tick();
        chk("ovr_no_second", 32'(m_valid), 32'h0);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'h0);

        // Set and clear in the same cycle
        m_ready  = 1'b0;
        avg_data = data_b;
        average();
        tick();
        tick();
        chk("setclr_valid", 32'(m_valid), 32'h1);
        avg_data = data_c;
        average();
        tick();
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("setclr_overrun", 32'(overrun), 32'h1);
        stream("setclr", data_b, 1'b0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        chk("setclr_clear", 32'(overrun), 32'h0);
        repeat (5) tick();

        // Back-to-back: next capture coincides with the m_last handshake
        m_ready  = 1'b1;
        avg_data = data_a;
        average();
        fft_valid = 1'b1;
        tick();
        tick();
        avg_data = data_b;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) fft_valid = 1'b0;
            chk("b2b_valid", 32'(m_valid), 32'h1);
            chk("b2b_data",  32'(m_data),  32'((k < 4) ? data_a[k % 4] : data_b[k % 4]));
            chk("b2b_bin",   32'(m_bin),   32'(k % 4));
            chk("b2b_last",  32'(m_last),  32'(k % 4 == 3));
            tick();
        end
        chk("b2b_after_valid", 32'(m_valid), 32'h0);
        chk("b2b_overrun", 32'(overrun), 32'h0);
        chk("b2b_fcnt", 32'(frame_cnt), 32'h0);
        repeat (5) tick();

        // Reset mid-stream
        avg_data = data_a;
        average();
        tick();
        tick();
        chk("rst_beat0", 32'(m_data), 32'h0001);
        tick();
        chk("rst_beat1", 32'(m_data), 32'h0002);
        tick();
        arest_n = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        tick();
        arest_n = 1'b1;
        tick();
        seen_valid = 0;
        for (int p = 0; p < 3; p++) begin
            fft_valid = 1'b1;
            if (m_valid) seen_valid++;
            tick();
            fft_valid = 1'b0;
            repeat (9) begin
                if (m_valid) seen_valid++;
                tick();
            end
        end
        repeat (10) begin
            if (m_valid) seen_valid++;
            tick();
        end
        chk("rst_no_valid", 32'(seen_valid), 32'h0);
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        tick();
        tick();
        stream("rst_restart", data_a, 1'b0);
        repeat (5) tick();

        // Wrap: 64 pulses give 16 streams
        avg_data = data_b;
        m_ready  = 1'b1;
        streams  = 0;
        for (int i = 0; i < 64; i++) begin
            fft_valid = 1'b1;
            if (m_valid && m_ready && m_last) streams++;
            tick();
            fft_valid = 1'b0;
            chk("wrap_fcnt", 32'(frame_cnt), 32'((i + 1) % 4));
            repeat (9) begin
                if (m_valid && m_ready && m_last) streams++;
                tick();
            end
        end
        chk("wrap_streams", 32'(streams), 32'd16);
        chk("wrap_overrun", 32'(overrun), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/n_bin_readout.md
# n_bin_readout

Readout end of the bin-averaging path: counts FFT frames, snapshots the parallel averaged-bin vector once per completed 2^N_AVGS-frame average, and streams the bins out one per beat over a valid/ready interface. It sits downstream of the N-bin averager, whose parallel output is this block's `avg_data`, and feeds the packetizer/DMA. Snapshots that arrive while a previous snapshot is still streaming are dropped and flagged.

## Interface
- `N`, 16, bin word width
- `N_AVGS`, 7, averages per result = 2^N_AVGS
- `BINS`, 4, bins per frame, ≥2
- `CAPTURE_DELAY`, 2, cycles from the terminal `fft_valid` to the `avg_data` sample, ≥1
- `clk`  in  1  clock
- `arest_n`  in  1  reset, asynchronous, active-low
- `fft_valid`  in  1  one-cycle pulse per FFT frame entering the averager
- `avg_data`  in  [BINS-1:0][N-1:0]  averaged bins from the averager
- `m_data`  out  N  current bin word
- `m_bin`  out  $clog2(BINS)  index of the current bin
- `m_valid`  out  1  beat valid
- `m_last`  out  1  high on the bin BINS-1 beat
- `m_ready`  in  1  downstream accept
- `overrun`  out  1  sticky, a snapshot was dropped
- `clear_overrun`  in  1  clears `overrun`
- `frame_cnt`  out  N_AVGS  frames counted in the current average

## Operation
- Frame counter: increments on each `fft_valid` and wraps from 2^N_AVGS-1 to 0. An `fft_valid` seen while the counter is at 2^N_AVGS-1 is the terminal frame.
- Terminal frame pushes a 1 into a CAPTURE_DELAY-deep shift register. Its output is the capture event.
- Snapshot register is BINS×N. On a capture event it loads `avg_data` if accepted.
- FSM with two states:
  - IDLE: on a capture event, load the snapshot, set the index to 0 and go to STREAM.
  - STREAM: `m_valid`=1, `m_data`=snapshot[index], `m_bin`=index, `m_last`=(index==BINS-1).
    - A handshake is `m_valid & m_ready`. A handshake at index < BINS-1 increments the index.
    - A handshake at BINS-1 returns to IDLE, unless a capture event occurs in the same cycle. In that case, reload the snapshot, set the index to 0 and stay in STREAM.
    - A capture event in STREAM without a final handshake in the same cycle is dropped: the snapshot is unchanged and `overrun` is set.
- `overrun`: set wins over `clear_overrun` in the same cycle. It holds until cleared or reset.
- `m_data`, `m_bin` and `m_last` are stable while `m_valid & !m_ready`. `m_valid` never drops without a handshake.
- Arithmetic: counters are unsigned and wrap. There is no saturation. Data is passed through bit-exact.

## Timing
- Reset (async assert, synchronous deassert at the top level) sets all outputs to 0: `m_data`, `m_bin`, `m_valid`, `m_last`, `overrun`, `frame_cnt`. The FSM goes to IDLE and the delay pipe and snapshot are cleared. Reset mid-stream abandons the snapshot. After release there is no `m_valid` until a new full average completes.
- Terminal `fft_valid` at the edge ending cycle t: the capture event is in cycle t+CAPTURE_DELAY, `avg_data` is sampled at that edge, and `m_valid`=1 from cycle t+CAPTURE_DELAY+1.
- With `m_ready` held high, BINS beats are on consecutive cycles. `m_valid` is low in the cycle after the last handshake unless it was reloaded.
- `frame_cnt` is registered. It shows the updated count the cycle after `fft_valid`.
- Latency from `fft_valid` to beats is independent of `m_ready`. Backpressure only delays completion, which risks an overrun.

## Test plan
Use BINS=4, N=16, N_AVGS=2, CAPTURE_DELAY=2.
- Basic: after reset, 4 `fft_valid` pulses 10 cycles apart, `avg_data`={0x0004,0x0003,0x0002,0x0001}, `m_ready`=1 -> beats 0x0001,0x0002,0x0003,0x0004 with `m_bin` 0..3. `m_last` is only on the 4th beat. The first beat is 3 cycles after the 4th pulse. `frame_cnt` reads 0 after the 4th pulse.
- Backpressure: same stimulus, `m_ready` toggling 1,0,0,1,… -> the same 4 words in order, each held stable while not ready. `overrun`=0.
- Overrun: `m_ready`=0 through a second complete average (4 more pulses), then `m_ready`=1 -> the first snapshot's 4 beats only, `overrun`=1. Pulse `clear_overrun` -> `overrun`=0 next cycle. Set and clear in the same cycle -> 1.
- Back-to-back: arrange a capture event in the same cycle as the `m_last` handshake -> 8 contiguous beats, `m_valid` never drops, second group holds the new data, `overrun`=0.
- Reset mid-stream: assert `arest_n`=0 after beat 2 -> all outputs 0 immediately. Release and apply 3 pulses -> no `m_valid`. Apply the 4th pulse -> a stream begins.
- Wrap: 64 pulses with `m_ready`=1 -> exactly 16 streams, `frame_cnt` sequence 1,2,3,0 repeating, `overrun`=0.
